// File: rtl/exec_mem_pkg.sv
// Shared types and defaults for the execute/memory responder: ALU opcodes,
// FSM states and datapath defaults.
package exec_mem_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int DEPTH_DEFAULT = 1024;
    localparam int ADDR_W        = 12;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1001,
        ALU_SRLI = 4'b1011,
        ALU_SRAI = 4'b1100,
        ALU_LUI  = 4'b1101
    } alu_op_e;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        MEM_RD,
        MEM_WR,
        RESP
    } state_e;

endpackage

// File: rtl/exec_alu.sv
// Purely combinational ALU; unknown opcodes yield zero and raise o_illegal.
module exec_alu
    import exec_mem_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  alu_op_e           i_op,
    input  logic [XLEN-1:0]   i_op1,
    input  logic [XLEN-1:0]   i_op2,
    output logic [XLEN-1:0]   o_result,
    output logic              o_illegal
);

    logic [4:0] w_shamt;
    assign w_shamt = i_op2[4:0];

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        o_result  = '0;
        o_illegal = 1'b0;
        case (i_op)
            ALU_ADD:            o_result = i_op1 + i_op2;
            ALU_SUB:            o_result = i_op1 - i_op2;
            ALU_SLL:            o_result = i_op1 << w_shamt;
            ALU_SLT:            o_result = XLEN'($signed(i_op1) < $signed(i_op2));
            ALU_SLTU:           o_result = XLEN'(i_op1 < i_op2);
            ALU_XOR:            o_result = i_op1 ^ i_op2;
            ALU_OR:             o_result = i_op1 | i_op2;
            ALU_AND:            o_result = i_op1 & i_op2;
            ALU_SRL, ALU_SRLI:  o_result = i_op1 >> w_shamt;
            ALU_SRA, ALU_SRAI:  o_result = $signed(i_op1) >>> w_shamt;
            ALU_LUI:            o_result = XLEN'({i_op1[19:0], 12'b0});
            default:            o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/exec_mem_unit.sv
// Execute/memory responder: runs one issued ALU op or word load/store per request.
// Build option MISALIGN_TRAP_EN traps memory requests whose address is not word aligned.
module exec_mem_unit
    import exec_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_DEFAULT,
    parameter int XLEN        = XLEN_DEFAULT
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [3:0]        alu_control_i,
    input  logic [XLEN-1:0]   op1_i,
    input  logic [XLEN-1:0]   op2_i,
    input  logic              mem_en_i,
    input  logic              mem_wr_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    output logic [XLEN-1:0]   write_data_o,
    output logic              write_valid_o,
    output logic              store_done_o,
    output logic              err_o
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_e              r_state;
    state_e              w_next_state;
    logic [3:0]          r_alu_ctl;
    logic [XLEN-1:0]     r_op1;
    logic [XLEN-1:0]     r_op2;
    logic [ADDR_W-1:0]   r_addr;
    logic [XLEN-1:0]     r_write_data;
    logic                r_write_valid;
    logic                r_store_done;
    logic                r_err;
    logic [XLEN-1:0]     r_mem [DEPTH_WORDS];

    logic                w_ready;
    logic                w_accept;
    logic                w_mem_we;
    logic                w_misalign;
    logic                w_alu_illegal;
    logic [XLEN-1:0]     w_alu_result;
    logic [XLEN-1:0]     w_load_data;
    logic [IDX_W-1:0]    w_idx;

    assign w_idx       = IDX_W'(32'(r_addr[ADDR_W-1:2]) % DEPTH_WORDS);
    assign w_load_data = w_misalign ? '0 : r_mem[w_idx];

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = (r_addr[1:0] != 2'b00);
`else
    logic w_unused_addr_lo;
    assign w_misalign       = 1'b0;
    assign w_unused_addr_lo = ^r_addr[1:0];
`endif

    exec_alu #(.XLEN(XLEN)) u_alu (
        .i_op      (alu_op_e'(r_alu_ctl)),
        .i_op1     (r_op1),
        .i_op2     (r_op2),
        .o_result  (w_alu_result),
        .o_illegal (w_alu_illegal)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_state <= IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid_i) begin
                    if (!mem_en_i)     w_next_state = EXEC;
                    else if (mem_wr_i) w_next_state = MEM_WR;
                    else               w_next_state = MEM_RD;
                end
            end
            EXEC:    w_next_state = RESP;
            MEM_RD:  w_next_state = RESP;
            MEM_WR:  w_next_state = IDLE;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_ready  = (r_state == IDLE);
        w_accept = w_ready && req_valid_i;
        w_mem_we = (r_state == MEM_WR) && !w_misalign;
    end

    // Capture on accept; pulses are registered so they appear in the cycle after the deciding state.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_alu_ctl     <= '0;
            r_op1         <= '0;
            r_op2         <= '0;
            r_addr        <= '0;
            r_write_data  <= '0;
            r_write_valid <= 1'b0;
            r_store_done  <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_write_valid <= 1'b0;
            r_store_done  <= 1'b0;
            if (w_accept) begin
                r_alu_ctl    <= alu_control_i;
                r_op1        <= op1_i;
                r_op2        <= op2_i;
                r_addr       <= mem_addr_i;
                r_store_done <= mem_en_i && mem_wr_i;
            end
            case (r_state)
                EXEC: begin
                    r_write_data  <= w_alu_result;
                    r_write_valid <= 1'b1;
                    if (w_alu_illegal) r_err <= 1'b1;
                end
                MEM_RD: begin
                    r_write_data  <= w_load_data;
                    r_write_valid <= 1'b1;
                    if (w_misalign) r_err <= 1'b1;
                end
                MEM_WR: begin
                    if (w_misalign) r_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the RAM array has no reset so it maps onto block memory; contents survive reset_i.
    always_ff @(posedge clk_i) begin
        if (w_mem_we) r_mem[w_idx] <= r_op1;
    end

    assign req_ready_o   = w_ready;
    assign write_data_o  = r_write_data;
    assign write_valid_o = r_write_valid;
    assign store_done_o  = r_store_done;
    assign err_o         = r_err;

endmodule

// File: tb/tb_exec_mem_unit.sv
// Directed bench for exec_mem_unit with a writeback scoreboard.
`timescale 1ns/1ps
module tb_exec_mem_unit;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [3:0]  alu_control_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic        mem_en_i;
    logic        mem_wr_i;
    logic [11:0] mem_addr_i;
    logic [31:0] write_data_o;
    logic        write_valid_o;
    logic        store_done_o;
    logic        err_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    exec_mem_unit #(.DEPTH_WORDS(1024), .XLEN(32)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .alu_control_i (alu_control_i),
        .op1_i         (op1_i),
        .op2_i         (op2_i),
        .mem_en_i      (mem_en_i),
        .mem_wr_i      (mem_wr_i),
        .mem_addr_i    (mem_addr_i),
        .write_data_o  (write_data_o),
        .write_valid_o (write_valid_o),
        .store_done_o  (store_done_o),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every writeback pulse must match the oldest expected value.
    always @(negedge clk_i) begin
        if (!reset_i && write_valid_o) begin
            if (exp_q.size() == 0) check("unexpected_write_valid", 32'd1, 32'd0);
            else                   check("write_data", write_data_o, exp_q.pop_front());
        end
    end

    // Drives one request in cycle 0; returns at mid-cycle 1 with req_valid_i dropped.
    task automatic send(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                        input logic en, input logic wr, input logic [11:0] addr);
        int guard = 0;
        @(negedge clk_i);
        while (!req_ready_o && guard < 20) begin
            @(negedge clk_i);
            guard++;
        end
        check("ready_before_send", {31'd0, req_ready_o}, 32'd1);
        alu_control_i = ctl;
        op1_i         = a;
        op2_i         = b;
        mem_en_i      = en;
        mem_wr_i      = wr;
        mem_addr_i    = addr;
        req_valid_i   = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i   = 1'b0;
    endtask

    // ALU op or load: pulse in cycle 2, ready back in cycle 3.
    task automatic run_op(input string tag, input logic [3:0] ctl, input logic [31:0] a,
                          input logic [31:0] b, input logic en, input logic [11:0] addr,
                          input logic [31:0] exp);
        exp_q.push_back(exp);
        send(ctl, a, b, en, 1'b0, addr);
        check({tag, "_ready_c1"}, {31'd0, req_ready_o}, 32'd0);
        check({tag, "_valid_c1"}, {31'd0, write_valid_o}, 32'd0);
        @(negedge clk_i);
        check({tag, "_valid_c2"}, {31'd0, write_valid_o}, 32'd1);
        check({tag, "_ready_c2"}, {31'd0, req_ready_o}, 32'd0);
        @(negedge clk_i);
        check({tag, "_valid_c3"}, {31'd0, write_valid_o}, 32'd0);
        check({tag, "_ready_c3"}, {31'd0, req_ready_o}, 32'd1);
    endtask

    task automatic run_store(input string tag, input logic [31:0] data, input logic [11:0] addr);
        send(4'h0, data, 32'h0, 1'b1, 1'b1, addr);
        check({tag, "_done_c1"}, {31'd0, store_done_o}, 32'd1);
        check({tag, "_valid_c1"}, {31'd0, write_valid_o}, 32'd0);
        @(negedge clk_i);
        check({tag, "_done_c2"}, {31'd0, store_done_o}, 32'd0);
        check({tag, "_ready_c2"}, {31'd0, req_ready_o}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i       = 1'b1;
        req_valid_i   = 1'b0;
        alu_control_i = '0;
        op1_i         = '0;
        op2_i         = '0;
        mem_en_i      = 1'b0;
        mem_wr_i      = 1'b0;
        mem_addr_i    = '0;
        repeat (2) @(negedge clk_i);
        check("rst_ready", {31'd0, req_ready_o}, 32'd1);
        check("rst_wdata", write_data_o, 32'd0);
        check("rst_valid", {31'd0, write_valid_o}, 32'd0);
        check("rst_done", {31'd0, store_done_o}, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        reset_i = 1'b0;

        run_op("add",  4'b0000, 32'd5, 32'd7, 1'b0, 12'h0, 32'd12);
        run_op("sub",  4'b1000, 32'd0, 32'd1, 1'b0, 12'h0, 32'hFFFF_FFFF);
        run_op("slt",  4'b0010, 32'hFFFF_FFFF, 32'd1, 1'b0, 12'h0, 32'd1);
        run_op("sltu", 4'b0011, 32'hFFFF_FFFF, 32'd1, 1'b0, 12'h0, 32'd0);
        run_op("sll",  4'b0001, 32'd1, 32'h0000_003F, 1'b0, 12'h0, 32'h8000_0000);
        run_op("xor",  4'b0100, 32'hF0F0_1234, 32'h0FF0_00FF, 1'b0, 12'h0, 32'hFF00_12CB);
        run_op("or",   4'b0110, 32'hF0F0_0000, 32'h0000_1234, 1'b0, 12'h0, 32'hF0F0_1234);
        run_op("and",  4'b0111, 32'hF0F0_FFFF, 32'h0FF0_1234, 1'b0, 12'h0, 32'h00F0_1234);
        run_op("sra",  4'b1001, 32'h8000_0000, 32'h0000_0404, 1'b0, 12'h0, 32'hF800_0000);
        run_op("srai", 4'b1100, 32'h8000_0000, 32'h0000_0404, 1'b0, 12'h0, 32'hF800_0000);
        run_op("srl",  4'b0101, 32'h8000_0000, 32'h0000_0404, 1'b0, 12'h0, 32'h0800_0000);
        run_op("srli", 4'b1011, 32'h8000_0000, 32'h0000_0404, 1'b0, 12'h0, 32'h0800_0000);
        run_op("lui",  4'b1101, 32'h000A_BCDE, 32'h0, 1'b0, 12'h0, 32'hABCD_E000);
        check("err_after_legal", {31'd0, err_o}, 32'd0);

        run_store("st_010", 32'hDEAD_BEEF, 12'h010);
        run_op("ld_010", 4'b1111, 32'h0, 32'h0, 1'b1, 12'h010, 32'hDEAD_BEEF);
        run_store("st_ffc", 32'h0BAD_F00D, 12'hFFC);
        run_op("ld_ffc", 4'b0000, 32'h0, 32'h0, 1'b1, 12'hFFC, 32'h0BAD_F00D);
        check("err_after_mem", {31'd0, err_o}, 32'd0);

        run_op("ill_1111", 4'b1111, 32'h1234_5678, 32'h1, 1'b0, 12'h0, 32'd0);
        check("err_set", {31'd0, err_o}, 32'd1);
        run_op("ill_1010", 4'b1010, 32'h1, 32'h1, 1'b0, 12'h0, 32'd0);
        run_op("add_err", 4'b0000, 32'd1, 32'd2, 1'b0, 12'h0, 32'd3);
        check("err_sticky", {31'd0, err_o}, 32'd1);

        // Reset in MEM_RD: the load is dropped and must not pulse.
        send(4'b0000, 32'h0, 32'h0, 1'b1, 1'b0, 12'h010);
        reset_i = 1'b1;
        #1;
        check("rstrd_ready_now", {31'd0, req_ready_o}, 32'd1);
        check("rstrd_valid_now", {31'd0, write_valid_o}, 32'd0);
        check("rstrd_err_clr", {31'd0, err_o}, 32'd0);
        @(negedge clk_i);
        check("rstrd_valid_hold", {31'd0, write_valid_o}, 32'd0);
        reset_i = 1'b0;
        @(negedge clk_i);
        check("rstrd_valid_after", {31'd0, write_valid_o}, 32'd0);
        check("rstrd_wdata", write_data_o, 32'd0);
        run_op("ld_keep", 4'b0000, 32'h0, 32'h0, 1'b1, 12'h010, 32'hDEAD_BEEF);

        // Misaligned store into word 4, then read the word back aligned and misaligned.
        run_store("st_013", 32'h1234_5678, 12'h013);
        check("mis_err", {31'd0, err_o}, {31'd0, TRAP});
        run_op("ld_w4", 4'b0000, 32'h0, 32'h0, 1'b1, 12'h010,
               TRAP ? 32'hDEAD_BEEF : 32'h1234_5678);
        run_op("ld_013", 4'b0000, 32'h0, 32'h0, 1'b1, 12'h013,
               TRAP ? 32'h0 : 32'h1234_5678);
        check("mis_err_final", {31'd0, err_o}, {31'd0, TRAP});

        repeat (2) @(negedge clk_i);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
